// File: rtl/intersection_traffic_model.sv
// Intersection model: per-lane car queues, sensors and a light checker.
// Closed-loop partner of the 3-street traffic light controller.
package light_package;
  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;
endpackage

module intersection_traffic_model
  import light_package::*;
#(
  parameter int QMAX     = 15,
  parameter int YEL_CYC  = 2,
  parameter int MAX_WAIT = 40,
  localparam int QW      = $clog2(QMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ew_str_arrive,
  input  logic          ew_left_arrive,
  input  logic          ns_arrive,
  input  colors         ew_str_light,
  input  colors         ew_left_light,
  input  colors         ns_light,
  output logic          ew_str_sensor,
  output logic          ew_left_sensor,
  output logic          ns_sensor,
  output logic [QW-1:0] ew_str_q,
  output logic [QW-1:0] ew_left_q,
  output logic [QW-1:0] ns_q,
  output logic [15:0]   served_cnt,
  output logic [7:0]    drop_cnt,
  output logic          conflict_err,
  output logic          seq_err,
  output logic          starve_err,
  output logic [1:0]    err_lane
);

  localparam int YW = $clog2(YEL_CYC + 2);
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [QW-1:0] QFULL = QW'(QMAX);
  localparam logic [YW-1:0] YLEN  = YW'(YEL_CYC);
  localparam logic [YW-1:0] YOVER = YW'(YEL_CYC + 1);
  localparam logic [WW-1:0] WLIM  = WW'(MAX_WAIT + 1);

  colors         light    [3];
  colors         prev     [3];
  logic [QW-1:0] q        [3];
  logic [QW-1:0] q_nxt    [3];
  logic [YW-1:0] ycnt     [3];
  logic [YW-1:0] ycnt_nxt [3];
  logic [WW-1:0] wcnt     [3];
  logic [WW-1:0] wcnt_nxt [3];

  logic [2:0] arr;
  logic [2:0] dep;
  logic [2:0] acc;
  logic [2:0] drop;
  logic [2:0] nonred;
  logic [2:0] trans_ok;
  logic [2:0] yel_bad;
  logic [2:0] seq_evt;
  logic [2:0] starve_evt;
  logic [2:0] lane_evt;
  logic       all_red;
  logic       conflict_evt;
  logic       any_err;
  logic       first_evt;
  logic [1:0] n_dep;
  logic [1:0] n_drop;
  logic [1:0] evt_lane;
  logic [8:0] drop_sum;

  assign arr      = {ns_arrive, ew_left_arrive, ew_str_arrive};
  assign light[0] = ew_str_light;
  assign light[1] = ew_left_light;
  assign light[2] = ns_light;

  always_comb begin
    dep        = '0;
    acc        = '0;
    drop       = '0;
    nonred     = '0;
    trans_ok   = '0;
    yel_bad    = '0;
    seq_evt    = '0;
    starve_evt = '0;
    all_red    = (prev[0] == red) && (prev[1] == red) &&
                 (prev[2] == red);
    for (int i = 0; i < 3; i++) begin
      q_nxt[i]    = q[i];
      ycnt_nxt[i] = '0;
      wcnt_nxt[i] = '0;
      nonred[i]   = (light[i] != red);

      // A full lane still takes a car when one leaves the same cycle
      dep[i]   = (light[i] == green) && (q[i] != '0);
      acc[i]   = arr[i] && ((q[i] < QFULL) || dep[i]);
      drop[i]  = arr[i] && !acc[i];
      q_nxt[i] = q[i] + QW'(acc[i]) - QW'(dep[i]);

      case ({prev[i], light[i]})
        {red, red},
        {green, green},
        {green, yellow},
        {yellow, yellow},
        {yellow, red}:   trans_ok[i] = 1'b1;
        {red, green}:    trans_ok[i] = all_red;
        default:         trans_ok[i] = 1'b0;
      endcase

      if (light[i] == yellow) begin
        ycnt_nxt[i] = (ycnt[i] == YOVER) ? YOVER
                                         : ycnt[i] + YW'(1);
        yel_bad[i]  = (ycnt[i] == YLEN);
      end else if (prev[i] == yellow) begin
        yel_bad[i]  = (ycnt[i] != YLEN);
      end
      seq_evt[i] = !trans_ok[i] || yel_bad[i];

      if ((light[i] != green) && (q[i] != '0)) begin
        wcnt_nxt[i]   = (wcnt[i] == WLIM) ? WLIM
                                          : wcnt[i] + WW'(1);
        starve_evt[i] = (wcnt[i] == WLIM - WW'(1));
      end
    end
    conflict_evt = (nonred[0] & nonred[1]) |
                   (nonred[0] & nonred[2]) |
                   (nonred[1] & nonred[2]);
  end

  assign lane_evt  = seq_evt | starve_evt;
  assign any_err   = conflict_err | seq_err | starve_err;
  assign first_evt = !any_err && (conflict_evt || (|lane_evt));
  assign n_dep     = 2'(dep[0]) + 2'(dep[1]) + 2'(dep[2]);
  assign n_drop    = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign drop_sum  = {1'b0, drop_cnt} + 9'(n_drop);

  // Lane code 3 covers conflicts and simultaneous multi-lane errors
  always_comb begin
    evt_lane = 2'd3;
    if (!conflict_evt && ($countones(lane_evt) == 1)) begin
      unique case (1'b1)
        lane_evt[0]: evt_lane = 2'd0;
        lane_evt[1]: evt_lane = 2'd1;
        lane_evt[2]: evt_lane = 2'd2;
        default:     evt_lane = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        q[i]    <= '0;
        prev[i] <= red;
        ycnt[i] <= '0;
        wcnt[i] <= '0;
      end
      served_cnt   <= '0;
      drop_cnt     <= '0;
      conflict_err <= 1'b0;
      seq_err      <= 1'b0;
      starve_err   <= 1'b0;
      err_lane     <= 2'd3;
    end else begin
      for (int i = 0; i < 3; i++) begin
        q[i]    <= q_nxt[i];
        prev[i] <= light[i];
        ycnt[i] <= ycnt_nxt[i];
        wcnt[i] <= wcnt_nxt[i];
      end
      served_cnt <= served_cnt + 16'(n_dep);
      drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (conflict_evt) conflict_err <= 1'b1;
      if (|seq_evt)     seq_err      <= 1'b1;
      if (|starve_evt)  starve_err   <= 1'b1;
      if (first_evt)    err_lane     <= evt_lane;
    end
  end

  assign ew_str_q       = q[0];
  assign ew_left_q      = q[1];
  assign ns_q           = q[2];
  assign ew_str_sensor  = (q[0] != '0);
  assign ew_left_sensor = (q[1] != '0);
  assign ns_sensor      = (q[2] != '0);

endmodule
